// File: rtl/mulres_fifo.sv
// ============================================================================
// Module   : mulres_fifo
// Purpose  : Result FIFO for the 24x24 multiplier/popcount peripheral with a
//            bus-mapped head/status/control window. Optional feature macro:
//            AUTOPOP_EN (a DATA_L read event also pops the head).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mulres_fifo #(
  parameter int          DEPTH     = 8,
  parameter int          PTR_W     = 3,
  parameter logic [15:0] BASE_ADDR = 16'h03C0
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             res_valid,
  input  logic [31:0]      res_w,
  input  logic [23:0]      res_l,
  input  logic             res_ovf,
  input  logic [15:0]      saddress,
  input  logic             srd,
  input  logic             swr,
  input  logic [31:0]      sdata_in,
  output logic [31:0]      sdata_out,
  output logic             fifo_irq,
  output logic [PTR_W:0]   level_out
);

  localparam logic [15:0]    A_DATA_W = BASE_ADDR;
  localparam logic [15:0]    A_DATA_L = BASE_ADDR + 16'h0008;
  localparam logic [15:0]    A_STATUS = BASE_ADDR + 16'h0010;
  localparam logic [15:0]    A_CTRL   = BASE_ADDR + 16'h0018;
  localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] LVL_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic             srd_d, swr_d;
  logic [PTR_W-1:0] wptr, rptr;
  logic [PTR_W:0]   level;
  logic [7:0]       lost_cnt;
  logic             ovf_seen;
  logic [56:0]      mem [DEPTH];
  logic [56:0]      head;
  logic [31:0]      rd_mux;
  logic [7:0]       level8;

  logic rd_ev, wr_ev, empty, full, ctrl_wr, clear, autopop, pop_req;
  logic do_pop, do_push, drop;
  logic unused_sdata;

  assign rd_ev   = srd & ~srd_d;
  assign wr_ev   = swr & ~swr_d;
  assign empty   = (level == '0);
  assign full    = (level == LVL_FULL);
  assign ctrl_wr = wr_ev & (saddress == A_CTRL);
  assign clear   = ctrl_wr & sdata_in[1];

`ifdef AUTOPOP_EN
  assign autopop = rd_ev & (saddress == A_DATA_L);
`else
  assign autopop = 1'b0;
`endif

  // CLEAR overrides both pop and push; a push blocked by CLEAR is not a loss
  assign pop_req = (ctrl_wr & sdata_in[0]) | autopop;
  assign do_pop  = pop_req & ~empty & ~clear;
  assign do_push = res_valid & ~clear & (~full | do_pop);
  assign drop    = res_valid & ~clear & full & ~do_pop;

  assign head      = mem[rptr];
  assign level8    = 8'(level);
  assign level_out = level;
  assign unused_sdata = ^sdata_in[31:2];

  always_comb begin
    rd_mux = '0;
    case (saddress)
      A_DATA_W: if (!empty) rd_mux = head[31:0];
      A_DATA_L: if (!empty) rd_mux = {7'b0, head[56:32]};
      A_STATUS: rd_mux = {8'h00, lost_cnt, level8, 5'b0, ovf_seen, full, empty};
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      srd_d     <= 1'b0;
      swr_d     <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      lost_cnt  <= '0;
      ovf_seen  <= 1'b0;
      sdata_out <= '0;
      fifo_irq  <= 1'b0;
    end else begin
      srd_d    <= srd;
      swr_d    <= swr;
      fifo_irq <= ~empty;
      if (rd_ev) sdata_out <= rd_mux;
      if (clear) begin
        wptr     <= '0;
        rptr     <= '0;
        level    <= '0;
        lost_cnt <= '0;
        ovf_seen <= 1'b0;
      end else begin
        if (do_push) wptr <= wptr + PTR_ONE;
        if (do_pop)  rptr <= rptr + PTR_ONE;
        case ({do_push, do_pop})
          2'b10:   level <= level + LVL_ONE;
          2'b01:   level <= level - LVL_ONE;
          default: level <= level;
        endcase
        if (do_push && res_ovf) ovf_seen <= 1'b1;
        if (drop && lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 8'd1;
      end
    end
  end

  // Storage is not reset; entries are only visible between rptr and wptr
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= {res_ovf, res_l, res_w};
  end

endmodule

`default_nettype wire

// File: doc/mulres_fifo.md
Name: mulres_fifo

Overview:
Downstream stage of the bus-mapped 24x24 multiplier / popcount peripheral. Captures each completed result (W, L, overflow flag) on the multiplier's one-cycle done pulse. Buffers results in a DEPTH-entry FIFO so software can drain several operations without losing any. Exposes FIFO head, status and control on the same 16-bit address bus, all in the clk domain.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..128
PTR_W, 3, log2(DEPTH); pointer width
BASE_ADDR, 16'h03C0, base of this block's register window

Ports:
clk  in  1  system clock
n_reset  in  1  reset, asynchronous, active-low
res_valid  in  1  one-cycle pulse from multiplier DONE state; push request
res_w  in  32  product low word W
res_l  in  24  ones count L
res_ovf  in  1  1 = product exceeded 32 bits (multiplier valid bit was 0)
saddress  in  16  bus address
srd  in  1  read strobe, level, clk-synchronous
swr  in  1  write strobe, level, clk-synchronous
sdata_in  in  32  write data
sdata_out  out  32  read data
fifo_irq  out  1  registered, 1 while FIFO non-empty
level_out  out  PTR_W+1  current occupancy

Behaviour:
- Reset is asynchronous: pointers, level, lost_cnt, ovf_seen, sdata_out, fifo_irq, srd_d and swr_d all go to 0. Storage contents are don't-care. Reset mid-drain discards all entries.
- Strobe edge detect: srd_d and swr_d are registered copies of the strobes. A read event is srd & ~srd_d; a write event is swr & ~swr_d. One action per strobe assertion.
- Register map (offsets from BASE_ADDR):
  - +0x00 DATA_W (RO): head W.
  - +0x08 DATA_L (RO): {7'b0, head ovf, head L}.
  - +0x10 STATUS (RO): [23:16] lost_cnt, [15:8] level zero-extended, [2] ovf_seen, [1] full, [0] empty.
  - +0x18 CTRL (WO): bit0 POP, bit1 CLEAR.
- Read latency: sdata_out loads on the clk edge that detects the read event. Value is valid from the next cycle and held until the next read event.
- Reads of DATA_W or DATA_L while empty return 0. A read of any unmapped address returns 0.
- Push: when res_valid=1 and not full, write {ovf, L, W} at the write pointer, wptr+1 (wraps mod DEPTH), level+1. If res_ovf=1, set ovf_seen (sticky).
- Push while full: entry dropped; lost_cnt+1, saturating at 255.
- Pop: a CTRL write with bit0=1 while non-empty gives rptr+1 (wraps), level-1. Pop while empty is ignored.
- Push and pop in the same cycle:
  - full: both succeed, level unchanged, no loss.
  - empty: push succeeds, pop ignored, level=1.
  - otherwise: both succeed, level unchanged.
- CLEAR (bit1=1): pointers, level, lost_cnt and ovf_seen go to 0. CLEAR wins over POP and over a simultaneous push; that push is discarded and not counted as lost.
- full = (level==DEPTH); empty = (level==0).
- fifo_irq = registered ~empty, updated one cycle after a level change.
- level_out = level (combinational from the register).

Optional Feature:
AUTOPOP_EN:
- Defined: a read event at DATA_L while non-empty also pops. sdata_out captures the pre-pop head, and the pop happens on the same edge. A CTRL POP in the same cycle is impossible (single bus). Simultaneous push follows the push/pop rules above.
- Undefined: DATA_L reads have no side effect; POP only via CTRL.

Test Plan:
- Reset, then read STATUS -> 0x00000001 (empty). fifo_irq=0, sdata_out=0.
- Push W=0x12345678, L=13, ovf=0; read DATA_W -> 0x12345678; read DATA_L -> 0x0000000D; CTRL POP -> STATUS 0x00000001.
- Push 10 results with DEPTH=8, ovf=1 on the 3rd -> STATUS 0x00020806 (lost=2, level=8, ovf_seen, full). First entry is still at head.
- Full FIFO, res_valid in the same cycle as a POP write -> level stays 8, lost_cnt unchanged. New entry is readable after 7 further pops.
- Push 3, then CTRL=0x3 in the same cycle as res_valid -> STATUS 0x00000001, lost_cnt=0. A following DATA_W read returns 0.
- AUTOPOP_EN: push A then B; read DATA_L twice -> returns A's then B's L; STATUS empty afterwards. Without the macro, level stays 2.
